// File: rtl/writeback_cycle_pkg.sv
// Shared types for the M/W back end: write-data select, load funct3 codes and default widths.
package writeback_cycle_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int REG_W_DEFAULT = 5;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  function automatic logic sel_writes(wb_sel_e s);
    return s != WB_RSVD;
  endfunction

endpackage

// File: rtl/writeback_cycle_if.sv
// Execute-side register-write tags in, register-file write port and M/W bypass taps out.
// retire_count exists only when WB_RETIRE_COUNT_EN is defined.
interface writeback_cycle_if
  import writeback_cycle_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int REGISTER_SIZE = REG_W_DEFAULT,
  parameter int CNT_WIDTH     = CNT_W_DEFAULT
);
  logic                     ex_valid;
  logic                     rf_write_enable;
  logic [REGISTER_SIZE-1:0] rf_write_addr;
  logic [1:0]               rf_write_data_sel;
  logic [XLEN-1:0]          ex_alu_result;
  logic [XLEN-1:0]          ex_pc_plus4;
  logic [2:0]               dm_load_type;
  logic [XLEN-1:0]          dm_read_data;
  logic                     stall;

  logic                     rf_writeback_enable;
  logic [REGISTER_SIZE-1:0] rf_writeback_addr;
  logic [XLEN-1:0]          rf_writeback_data;
  logic                     m_fwd_valid;
  logic [REGISTER_SIZE-1:0] m_fwd_addr;
  logic [XLEN-1:0]          m_fwd_data;
  logic                     w_fwd_valid;
  logic [REGISTER_SIZE-1:0] w_fwd_addr;
  logic [XLEN-1:0]          w_fwd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_WIDTH-1:0]     retire_count;
`endif

  modport master (
    output ex_valid, rf_write_enable, rf_write_addr, rf_write_data_sel,
           ex_alu_result, ex_pc_plus4, dm_load_type, dm_read_data, stall,
    input  rf_writeback_enable, rf_writeback_addr, rf_writeback_data,
           m_fwd_valid, m_fwd_addr, m_fwd_data, w_fwd_valid, w_fwd_addr, w_fwd_data
`ifdef WB_RETIRE_COUNT_EN
    , input retire_count
`endif
  );

  modport slave (
    input  ex_valid, rf_write_enable, rf_write_addr, rf_write_data_sel,
           ex_alu_result, ex_pc_plus4, dm_load_type, dm_read_data, stall,
    output rf_writeback_enable, rf_writeback_addr, rf_writeback_data,
           m_fwd_valid, m_fwd_addr, m_fwd_data, w_fwd_valid, w_fwd_addr, w_fwd_data
`ifdef WB_RETIRE_COUNT_EN
    , output retire_count
`endif
  );
endinterface

// File: rtl/writeback_cycle_load_aligner.sv
// Combinational load formatter: picks byte/half/word at the address offset and sign/zero extends.
// Unknown funct3 reports legal_o=0 with zero data.
module load_aligner
  import writeback_cycle_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      offset_i,
  input  load_type_e      load_type_i,
  output logic [XLEN-1:0] data_o,
  output logic            legal_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = word_i[{offset_i, 3'b000} +: 8];
    half_v  = word_i[{offset_i[1], 4'b0000} +: 16];
    data_o  = '0;
    legal_o = 1'b1;
    case (load_type_i)
      LT_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LT_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      LT_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      LT_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      LT_LW:   data_o = word_i;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/writeback_cycle.sv
// M and W pipeline registers feeding the register-file write port; ex sampled at edge N writes after edge N+1.
// stall holds M and bubbles W. Optional retire counter behind WB_RETIRE_COUNT_EN.
module writeback_cycle
  import writeback_cycle_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int REGISTER_SIZE = REG_W_DEFAULT,
  parameter int CNT_WIDTH     = CNT_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  writeback_cycle_if.slave bus
);
  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [REGISTER_SIZE-1:0] rd;
    wb_sel_e                  sel;
    logic [XLEN-1:0]          alu;
    logic [XLEN-1:0]          pc4;
    load_type_e               lt;
  } m_stage_t;

  typedef struct packed {
    logic                     we;
    logic [REGISTER_SIZE-1:0] rd;
    logic [XLEN-1:0]          data;
  } wb_stage_t;

  m_stage_t        m_q, m_d;
  wb_stage_t       w_q, w_d;
  logic [XLEN-1:0] ld_data;
  logic            ld_legal;
  logic [XLEN-1:0] m_data;
  logic            m_we;

  load_aligner #(.XLEN(XLEN)) u_load_aligner (
    .word_i      (bus.dm_read_data),
    .offset_i    (m_q.alu[1:0]),
    .load_type_i (m_q.lt),
    .data_o      (ld_data),
    .legal_o     (ld_legal)
  );

  // Upstream holds its outputs during stall, so M simply ignores them.
  always_comb begin
    m_d = m_q;
    if (!bus.stall) begin
      m_d.valid = bus.ex_valid;
      m_d.we    = bus.rf_write_enable;
      m_d.rd    = bus.rf_write_addr;
      m_d.sel   = wb_sel_e'(bus.rf_write_data_sel);
      m_d.alu   = bus.ex_alu_result;
      m_d.pc4   = bus.ex_pc_plus4;
      m_d.lt    = load_type_e'(bus.dm_load_type);
    end
  end

  always_comb begin
    m_we   = m_q.valid & m_q.we & (m_q.rd != '0) & sel_writes(m_q.sel);
    m_data = '0;
    case (m_q.sel)
      WB_ALU:  m_data = m_q.alu;
      WB_LINK: m_data = m_q.pc4;
      WB_LOAD: begin
        m_data = ld_data;
        m_we   = m_we & ld_legal;
      end
      default: m_data = '0;
    endcase
    w_d = '0;
    if (!bus.stall) begin
      w_d.we   = m_we;
      w_d.rd   = m_q.rd;
      w_d.data = m_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign bus.rf_writeback_enable = w_q.we;
  assign bus.rf_writeback_addr   = w_q.rd;
  assign bus.rf_writeback_data   = w_q.data;
  assign bus.w_fwd_valid         = w_q.we;
  assign bus.w_fwd_addr          = w_q.rd;
  assign bus.w_fwd_data          = w_q.data;
  // Load data is not ready for bypass until it reaches W.
  assign bus.m_fwd_valid         = m_we & (m_q.sel != WB_LOAD);
  assign bus.m_fwd_addr          = m_q.rd;
  assign bus.m_fwd_data          = m_data;

`ifdef WB_RETIRE_COUNT_EN
  logic                 w_valid_q;
  logic [CNT_WIDTH-1:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      w_valid_q <= ~bus.stall & m_q.valid;
      retire_q  <= retire_q + CNT_WIDTH'(w_valid_q);
    end
  end

  assign bus.retire_count = retire_q;
`endif
endmodule
